riscv_issue_ctl: RTL

Single-issue scoreboard controller between the decode unit (IDU) and execute (EXU). It buffers one decoded instruction (`riscv_pkg::idu_t`) and holds it until all source and destination registers are free of pending writes and the multiply/divide unit is available. It then issues the instruction to EXU and drives the `REGISTER_PORTS` register-file read addresses. Writebacks clear scoreboard entries, and a flush discards the buffered instruction.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/riscv_scoreboard.sv | 54 +++++
 rtl/riscv_issue_ctl.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V decode/issue path.
//   op_t          : decoded operation
//   idu_t         : decoded instruction record passed from IDU to EXU
//   scoreboard_t  : one pending-write bit per architectural register
//   is_md_op()    : true for operations that occupy the multiply/divide unit
package riscv_pkg;

  localparam int REGISTER_PORTS = 2;

  typedef enum logic [5:0] {
    ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
    ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI, SLTIU,
    LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    ILLEGAL, ECALL, EBREAK, FENCE
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_used;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
  } idu_t;

  typedef logic [31:0] scoreboard_t;

  function automatic logic is_md_op(op_t o);
    case (o)
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// Pending-write scoreboard for the 32 integer registers.
//   clk, rst    : clock, asynchronous active-high reset
//   wb_valid/wb_rd : writeback clears the pending bit of wb_rd
//   set_en/set_rd  : issue of a register-writing op marks set_rd pending
//   lk_addr/lk_busy: three combinational lookups (rs1, rs2, rd)
//   sb_err      : sticky, writeback seen for a register that was not pending
module riscv_scoreboard
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            set_en,
  input  logic [4:0]      set_rd,
  input  logic [2:0][4:0] lk_addr,
  output logic [2:0]      lk_busy,
  output logic            sb_err
);

  scoreboard_t sb_q, sb_d;
  logic        sb_err_q, sb_err_d;

  always_comb begin
    sb_d     = sb_q;
    sb_err_d = sb_err_q;
    if (wb_valid && (wb_rd != 5'd0)) begin
      sb_d[wb_rd] = 1'b0;
      if (!sb_q[wb_rd]) sb_err_d = 1'b1;
    end
    // Applied after the clear so an issue and a writeback to the same
    // register in one cycle leave the register pending.
    if (set_en && (set_rd != 5'd0)) sb_d[set_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q     <= '0;
      sb_err_q <= 1'b0;
    end else begin
      sb_q     <= sb_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_comb begin
    lk_busy = '0;
    for (int unsigned i = 0; i < 3; i++) lk_busy[i] = sb_q[lk_addr[i]];
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/riscv_issue_ctl.sv
// Single-entry issue stage between IDU and EXU.
// Holds one decoded instruction until its source/destination registers have
// no pending writes and, for mul/div ops, the M unit is free; then issues it.
//   clk, rst            : clock, asynchronous active-high reset
//   idu_valid/idu_ready/idu : decoded instruction handshake
//   exu_valid/exu_ready/exu : issue handshake, exu is the held copy
//   rf_raddr            : register-file read addresses (0 = rs1, 1 = rs2)
//   md_busy             : multiply/divide unit occupied
//   wb_valid/wb_rd      : register writeback
//   flush               : discard the held instruction
//   stall_cnt           : saturating count of hazard stalls with EXU ready
//   sb_err              : sticky writeback-to-non-pending-register error
module riscv_issue_ctl
  import riscv_pkg::*;
#(
  parameter int REGISTER_PORTS = riscv_pkg::REGISTER_PORTS,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           idu_valid,
  output logic                           idu_ready,
  input  idu_t                           idu,
  output logic                           exu_valid,
  input  logic                           exu_ready,
  output idu_t                           exu,
  output logic [REGISTER_PORTS-1:0][4:0] rf_raddr,
  input  logic                           md_busy,
  input  logic                           wb_valid,
  input  logic [4:0]                     wb_rd,
  input  logic                           flush,
  output logic [STALL_CNT_W-1:0]         stall_cnt,
  output logic                           sb_err
);

  logic                   hold_valid_q, hold_valid_d;
  idu_t                   hold_q, hold_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [2:0][4:0] lk_addr;
  logic [2:0]      lk_busy;
  logic            hazard;
  logic            issue;
  logic            accept;

  assign lk_addr[0] = hold_q.rs1;
  assign lk_addr[1] = hold_q.rs2;
  assign lk_addr[2] = hold_q.rd;

  riscv_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .set_en   (issue && hold_q.rd_used),
    .set_rd   (hold_q.rd),
    .lk_addr  (lk_addr),
    .lk_busy  (lk_busy),
    .sb_err   (sb_err)
  );

  always_comb begin
    hazard = (hold_q.rs1_used && lk_busy[0]) ||
             (hold_q.rs2_used && lk_busy[1]) ||
             (hold_q.rd_used  && lk_busy[2]) ||
             (is_md_op(hold_q.op) && md_busy);
    exu_valid = hold_valid_q && !hazard && !flush;
    issue     = exu_valid && exu_ready;
    idu_ready = !flush && (!hold_valid_q || issue);
    accept    = idu_valid && idu_ready;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_d       = idu;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_valid_q && hazard && exu_ready && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    rf_raddr = '0;
    if (hold_valid_q) begin
      for (int unsigned p = 0; p < REGISTER_PORTS; p++) begin
        if (p == 0)      rf_raddr[p] = hold_q.rs1;
        else if (p == 1) rf_raddr[p] = hold_q.rs2;
      end
    end
  end

  assign exu       = hold_q;
  assign stall_cnt = stall_cnt_q;

endmodule
